// File: rtl/uart_alici_prm.sv
// UART receiver: 2-flop input synchroniser, frame FSM with latched configuration,
// and a fall-through receive FIFO carrying parity/framing flags with each word.
module uart_alici_prm #(
    parameter int VERI_BIT      = 8,
    parameter int FIFO_DERINLIK = 4
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic                             rx_i,
    input  logic [15:0]                      baud_div_i,
    input  logic [1:0]                       parite_mod_i,
    input  logic                             durak_bit_i,
    output logic [VERI_BIT-1:0]              veri_o,
    output logic                             parite_hata_o,
    output logic                             cerceve_hata_o,
    output logic                             veri_gecerli_o,
    input  logic                             veri_hazir_i,
    output logic                             tasma_o,
    input  logic                             tasma_temizle_i,
    output logic [$clog2(FIFO_DERINLIK):0]   doluluk_o,
    output logic                             mesgul_o
);
    localparam int AW = $clog2(FIFO_DERINLIK);
    localparam int KW = VERI_BIT + 2;

    typedef enum logic [2:0] {BOSTA, BASLA, VERI, PARITE, DURAK} durum_t;

    durum_t              state_q, state_d;
    logic                rx_s1_q, rx_s2_q;
    logic [15:0]         cnt_q, cnt_d;
    logic [3:0]          bit_q, bit_d;
    logic [15:0]         div_q, div_d;
    logic [1:0]          mod_q, mod_d;
    logic                stop2_q, stop2_d;
    logic [VERI_BIT-1:0] data_q, data_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                push, push_ferr, sample;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            state_q <= BOSTA;
            cnt_q   <= '0;
            bit_q   <= '0;
            div_q   <= 16'd4;
            mod_q   <= '0;
            stop2_q <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rx_s1_q <= rx_i;
            rx_s2_q <= rx_s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            mod_q   <= mod_d;
            stop2_q <= stop2_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign sample = (cnt_q == div_q - 16'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        div_d     = div_q;
        mod_d     = mod_q;
        stop2_d   = stop2_q;
        data_d    = data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        push      = 1'b0;
        push_ferr = ferr_q;
        case (state_q)
            BOSTA: begin
                if (!rx_s2_q) begin
                    state_d = BASLA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    div_d   = (baud_div_i < 16'd4) ? 16'd4 : baud_div_i;
                    mod_d   = parite_mod_i;
                    stop2_d = durak_bit_i;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            BASLA: begin
                // Start bit is re-checked at mid-bit to reject glitches.
                if (cnt_q == (div_q >> 1) - 16'd1) begin
                    cnt_d   = '0;
                    state_d = rx_s2_q ? BOSTA : VERI;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            VERI: begin
                if (sample) begin
                    cnt_d  = '0;
                    data_d = {rx_s2_q, data_q[VERI_BIT-1:1]};
                    if (bit_q == 4'(VERI_BIT - 1)) begin
                        bit_d   = '0;
                        state_d = (mod_q == 2'b01 || mod_q == 2'b10) ? PARITE : DURAK;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            PARITE: begin
                if (sample) begin
                    cnt_d   = '0;
                    perr_d  = (^data_q) ^ rx_s2_q ^ (mod_q == 2'b10);
                    state_d = DURAK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DURAK: begin
                if (sample) begin
                    cnt_d = '0;
                    if (!rx_s2_q) ferr_d = 1'b1;
                    if (bit_q == {3'b000, stop2_q}) begin
                        push      = 1'b1;
                        push_ferr = ferr_q | ~rx_s2_q;
                        bit_d     = '0;
                        state_d   = BOSTA;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = BOSTA;
        endcase
    end

    assign mesgul_o = (state_q != BOSTA);

    logic [KW-1:0] mem_q [FIFO_DERINLIK];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   fcnt_q;
    logic          tasma_q;
    logic          full, valid, pop, wr_en, ovf;
    logic [KW-1:0] head;

    assign full  = (fcnt_q == (AW+1)'(FIFO_DERINLIK));
    assign valid = (fcnt_q != '0);
    assign pop   = valid & veri_hazir_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_en = push & (~full | pop);
    assign ovf   = push & full & ~pop;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            fcnt_q  <= '0;
            tasma_q <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop)   rd_q <= rd_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   fcnt_q <= fcnt_q + 1'b1;
                2'b01:   fcnt_q <= fcnt_q - 1'b1;
                default: fcnt_q <= fcnt_q;
            endcase
            if (ovf)                  tasma_q <= 1'b1;
            else if (tasma_temizle_i) tasma_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_q] <= {perr_q, push_ferr, data_q};
    end

    assign head           = mem_q[rd_q];
    assign veri_o         = valid ? head[VERI_BIT-1:0] : '0;
    assign cerceve_hata_o = valid & head[VERI_BIT];
    assign parite_hata_o  = valid & head[VERI_BIT+1];
    assign veri_gecerli_o = valid;
    assign tasma_o        = tasma_q;
    assign doluluk_o      = fcnt_q;

endmodule
